// File: rtl/cgra_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cgra_bram_pkg
// Description : Shared defaults and helpers for the CGRA BRAM port responder:
//               data width / byte-lane defaults, legal read latencies and
//               the byte-lane slice helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cgra_bram_pkg;

  localparam int unsigned SYS_DWIDTH_DEFAULT = 32;
  localparam int unsigned BYTE_LEN_DEFAULT   = 4;
  localparam int unsigned READ_LATENCY_MIN   = 1;
  localparam int unsigned READ_LATENCY_MAX   = 2;

  // Only a one- or two-stage read pipeline is supported.
  function automatic bit read_latency_is_legal(input int unsigned lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

  // LSB position of byte lane 'lane' inside a data word.
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return 8 * lane;
  endfunction

endpackage : cgra_bram_pkg
`default_nettype wire

// File: rtl/bram_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : bram_byte_lane
// Description : One 8-bit x 2^AWIDTH memory lane with write enable and a
//               registered read port. Read-first by default; write-first when
//               BRAM_RESPONDER_WRITE_FIRST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_byte_lane #(
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_clr,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] addr,
  input  logic [7:0]        wr_byte,
  output logic [7:0]        rd_byte
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] fetch_byte;
  logic [7:0] rd_byte_d;
  logic [7:0] rd_byte_q;

  // Memory array: contents survive reset; the top already gates wr_en.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_byte;
    end
  end

  // Collision policy and next value of the read register.
  always_comb begin
`ifdef BRAM_RESPONDER_WRITE_FIRST_EN
    fetch_byte = wr_en ? wr_byte : mem[addr];
`else
    fetch_byte = mem[addr];
`endif
    rd_byte_d = rd_byte_q;
    if (rd_clr) begin
      rd_byte_d = 8'h00;
    end else if (rd_en) begin
      rd_byte_d = rd_zero ? 8'h00 : fetch_byte;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_byte_q <= 8'h00;
    end else begin
      rd_byte_q <= rd_byte_d;
    end
  end

  assign rd_byte = rd_byte_q;

endmodule : bram_byte_lane
`default_nettype wire

// File: rtl/bram_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_responder
// Description : Memory end of the CGRA BRAM port: byte-enable writes,
//               1- or 2-cycle read latency, sticky out-of-range flag and
//               saturating access counters. Optional macro
//               BRAM_RESPONDER_WRITE_FIRST_EN selects write-first collisions.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_responder
  import cgra_bram_pkg::*;
#(
  parameter int unsigned SYS_DWIDTH   = SYS_DWIDTH_DEFAULT,
  parameter int unsigned BYTE_LEN     = BYTE_LEN_DEFAULT,
  parameter int unsigned AWIDTH       = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic                  Port_Rst,
  input  logic                  Port_En,
  input  logic [BYTE_LEN-1:0]   Port_Wen,
  input  logic [SYS_DWIDTH-1:0] Port_Addr,
  input  logic [SYS_DWIDTH-1:0] Port_Data_To_Bram,
  output logic [SYS_DWIDTH-1:0] Port_Data_From_Bram,
  input  logic                  Clear_Stats,
  output logic                  Addr_Err,
  output logic [31:0]           Rd_Count,
  output logic [31:0]           Wr_Count
);

  // Elaboration-time parameter sanity.
  if (!read_latency_is_legal(READ_LATENCY)) begin : g_bad_latency
    $error("bram_port_responder: READ_LATENCY must be 1 or 2");
  end
  if (SYS_DWIDTH != 8 * BYTE_LEN) begin : g_bad_width
    $error("bram_port_responder: SYS_DWIDTH must equal 8*BYTE_LEN");
  end

  logic              in_range;
  logic              access;
  logic              is_write;
  logic              is_read;
  logic              rd_clr;
  logic [AWIDTH-1:0] word_idx;
  logic [SYS_DWIDTH-1:0] stage1_data;
  logic              unused_addr_lsbs;

  logic              addr_err_d, addr_err_q;
  logic [31:0]       rd_count_d, rd_count_q;
  logic [31:0]       wr_count_d, wr_count_q;

  // Byte address to word index; the two byte-offset bits carry no meaning.
  assign word_idx         = Port_Addr[AWIDTH+1:2];
  assign unused_addr_lsbs = ^Port_Addr[1:0];

  // Any address bit above the word index puts the access out of range.
  if (SYS_DWIDTH > AWIDTH + 2) begin : g_range_check
    assign in_range = (Port_Addr[SYS_DWIDTH-1:AWIDTH+2] == '0);
  end else begin : g_range_full
    assign in_range = 1'b1;
  end

  // Accesses issued while in reset are ignored entirely.
  assign access   = Resetn && Port_En;
  assign is_write = access && (Port_Wen != '0);
  assign is_read  = access && (Port_Wen == '0);
  assign rd_clr   = Port_Rst;

  for (genvar i = 0; i < BYTE_LEN; i++) begin : g_lane
    bram_byte_lane #(
      .AWIDTH (AWIDTH)
    ) u_lane (
      .clk     (Clk),
      .rst_n   (Resetn),
      .rd_clr  (rd_clr),
      .rd_en   (access),
      .rd_zero (!in_range),
      .wr_en   (access && in_range && Port_Wen[i]),
      .addr    (word_idx),
      .wr_byte (Port_Data_To_Bram[lane_lsb(i) +: 8]),
      .rd_byte (stage1_data[lane_lsb(i) +: 8])
    );
  end

  if (READ_LATENCY == 2) begin : g_latency2
    logic                  en_d, en_q;
    logic [SYS_DWIDTH-1:0] stage2_d, stage2_q;

    // Second stage only advances on the cycle after an enabled access.
    always_comb begin
      en_d     = access;
      stage2_d = stage2_q;
      if (Port_Rst) begin
        stage2_d = '0;
      end else if (en_q) begin
        stage2_d = stage1_data;
      end
    end

    // Second-stage output register and its load qualifier.
    always_ff @(posedge Clk) begin
      if (!Resetn) begin
        en_q     <= 1'b0;
        stage2_q <= '0;
      end else begin
        en_q     <= en_d;
        stage2_q <= stage2_d;
      end
    end

    assign Port_Data_From_Bram = stage2_q;
  end else begin : g_latency1
    assign Port_Data_From_Bram = stage1_data;
  end

  // Sticky error flag and saturating counters; a clear beats a same-cycle access.
  always_comb begin
    addr_err_d = addr_err_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (Clear_Stats) begin
      addr_err_d = 1'b0;
      rd_count_d = '0;
      wr_count_d = '0;
    end else begin
      if (access && !in_range) begin
        addr_err_d = 1'b1;
      end
      if (is_read && (rd_count_q != 32'hFFFF_FFFF)) begin
        rd_count_d = rd_count_q + 32'd1;
      end
      if (is_write && (wr_count_q != 32'hFFFF_FFFF)) begin
        wr_count_d = wr_count_q + 32'd1;
      end
    end
  end

  // Status registers.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      addr_err_q <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      addr_err_q <= addr_err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign Addr_Err = addr_err_q;
  assign Rd_Count = rd_count_q;
  assign Wr_Count = wr_count_q;

endmodule : bram_port_responder
`default_nettype wire

// File: tb/tb_bram_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_responder
// Description : Directed bench driving a READ_LATENCY=1 and a READ_LATENCY=2
//               responder with the same stimulus and checking both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_responder;

  logic        Clk = 1'b0;
  logic        Resetn;
  logic        Port_Rst;
  logic        Port_En;
  logic [3:0]  Port_Wen;
  logic [31:0] Port_Addr;
  logic [31:0] Port_Data_To_Bram;
  logic        Clear_Stats;

  logic [31:0] out1, out2;
  logic        err1, err2;
  logic [31:0] rd1, rd2, wr1, wr2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  bram_port_responder #(
    .SYS_DWIDTH (32), .BYTE_LEN (4), .AWIDTH (10), .READ_LATENCY (1)
  ) u_dut_l1 (
    .Clk (Clk), .Resetn (Resetn), .Port_Rst (Port_Rst), .Port_En (Port_En),
    .Port_Wen (Port_Wen), .Port_Addr (Port_Addr),
    .Port_Data_To_Bram (Port_Data_To_Bram), .Port_Data_From_Bram (out1),
    .Clear_Stats (Clear_Stats), .Addr_Err (err1),
    .Rd_Count (rd1), .Wr_Count (wr1)
  );

  bram_port_responder #(
    .SYS_DWIDTH (32), .BYTE_LEN (4), .AWIDTH (10), .READ_LATENCY (2)
  ) u_dut_l2 (
    .Clk (Clk), .Resetn (Resetn), .Port_Rst (Port_Rst), .Port_En (Port_En),
    .Port_Wen (Port_Wen), .Port_Addr (Port_Addr),
    .Port_Data_To_Bram (Port_Data_To_Bram), .Port_Data_From_Bram (out2),
    .Clear_Stats (Clear_Stats), .Addr_Err (err2),
    .Rd_Count (rd2), .Wr_Count (wr2)
  );

`ifdef BRAM_RESPONDER_WRITE_FIRST_EN
  localparam logic [31:0] C_MERGE_EXP   = 32'h11BB_33DD;
  localparam logic [31:0] C_COLLIDE_EXP = 32'h0000_0002;
`else
  localparam logic [31:0] C_MERGE_EXP   = 32'h1122_3344;
  localparam logic [31:0] C_COLLIDE_EXP = 32'h0000_0001;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    Port_En = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One enabled access for one edge, then En drops until the next call.
  task automatic acc(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
    Port_En           = 1'b1;
    Port_Wen          = wen;
    Port_Addr         = addr;
    Port_Data_To_Bram = data;
    tick();
    Port_En  = 1'b0;
    Port_Wen = 4'h0;
  endtask

  initial begin
    Resetn = 1'b0; Port_Rst = 1'b0; Port_En = 1'b0; Port_Wen = 4'h0;
    Port_Addr = '0; Port_Data_To_Bram = '0; Clear_Stats = 1'b0;
    #1;
    idle(3);
    check_eq("rst_out_l1", out1, 32'h0);
    check_eq("rst_out_l2", out2, 32'h0);
    check_eq("rst_err", {30'd0, err1, err2}, 32'h0);
    check_eq("rst_rdcnt", rd1 | rd2, 32'h0);
    check_eq("rst_wrcnt", wr1 | wr2, 32'h0);
    Resetn = 1'b1;
    idle(1);

    // Byte-lane writes and latency
    acc(4'hF, 32'h10, 32'h1122_3344);
    acc(4'h5, 32'h10, 32'hAABB_CCDD);
    acc(4'h0, 32'h10, 32'h0);
    check_eq("merge_l1", out1, 32'h11BB_33DD);
    check_eq("merge_l2_prev", out2, C_MERGE_EXP);
    idle(1);
    check_eq("merge_l2", out2, 32'h11BB_33DD);
    check_eq("merge_l1_hold", out1, 32'h11BB_33DD);

    // Read/write collision
    acc(4'hF, 32'h20, 32'h1);
    acc(4'hF, 32'h20, 32'h2);
    check_eq("collide_l1", out1, C_COLLIDE_EXP);
    idle(1);
    check_eq("collide_l2", out2, C_COLLIDE_EXP);
    acc(4'h0, 32'h20, 32'h0);
    check_eq("after_collide_l1", out1, 32'h2);
    idle(1);
    check_eq("after_collide_l2", out2, 32'h2);

    // Out of range: 0x1000 aliases word 0 if the range check were missing
    acc(4'hF, 32'h0, 32'h5566_7788);
    acc(4'hF, 32'h1000, 32'hDEAD_BEEF);
    check_eq("oor_err_l1", {31'd0, err1}, 32'h1);
    check_eq("oor_err_l2", {31'd0, err2}, 32'h1);
    check_eq("oor_wr_out_l1", out1, 32'h0);
    idle(1);
    check_eq("oor_wr_out_l2", out2, 32'h0);
    acc(4'h0, 32'h1000, 32'h0);
    check_eq("oor_rd_l1", out1, 32'h0);
    acc(4'h0, 32'h0, 32'h0);
    check_eq("oor_mem_intact", out1, 32'h5566_7788);
    idle(2);
    check_eq("oor_err_sticky", {30'd0, err1, err2}, 32'h3);
    Clear_Stats = 1'b1;
    tick();
    Clear_Stats = 1'b0;
    check_eq("oor_err_clear", {30'd0, err1, err2}, 32'h0);

    // Port_Rst beats the output load but not the write
    Port_Rst = 1'b1;
    acc(4'hF, 32'h4, 32'h5);
    Port_Rst = 1'b0;
    check_eq("prst_l1", out1, 32'h0);
    check_eq("prst_l2", out2, 32'h0);
    acc(4'h0, 32'h4, 32'h0);
    check_eq("prst_wr_l1", out1, 32'h5);
    idle(1);
    check_eq("prst_wr_l2", out2, 32'h5);

    // Hold and counters
    Clear_Stats = 1'b1;
    tick();
    Clear_Stats = 1'b0;
    acc(4'hF, 32'h8, 32'hCAFE_F00D);
    acc(4'h0, 32'h8, 32'h0);
    idle(10);
    check_eq("hold_l1", out1, 32'hCAFE_F00D);
    check_eq("hold_l2", out2, 32'hCAFE_F00D);
    acc(4'h0, 32'h10, 32'h0);
    acc(4'h3, 32'h14, 32'h0);
    acc(4'h0, 32'h20, 32'h0);
    check_eq("rdcnt_l1", rd1, 32'd3);
    check_eq("wrcnt_l1", wr1, 32'd2);
    check_eq("rdcnt_l2", rd2, 32'd3);
    check_eq("wrcnt_l2", wr2, 32'd2);
    Clear_Stats = 1'b1;
    acc(4'h0, 32'h10, 32'h0);
    Clear_Stats = 1'b0;
    check_eq("clr_wins_rd", rd1 | rd2, 32'h0);
    check_eq("clr_wins_wr", wr1 | wr2, 32'h0);

    // Reset in the middle of a latency-2 read; write during reset ignored
    acc(4'h0, 32'h10, 32'h0);
    Resetn = 1'b0;
    acc(4'hF, 32'h10, 32'hFFFF_FFFF);
    check_eq("midrst_out_l2", out2, 32'h0);
    check_eq("midrst_out_l1", out1, 32'h0);
    check_eq("midrst_cnt", rd2 | wr2, 32'h0);
    Resetn = 1'b1;
    idle(2);
    check_eq("postrst_idle_l2", out2, 32'h0);
    acc(4'h0, 32'h10, 32'h0);
    idle(1);
    check_eq("postrst_mem_l2", out2, 32'h11BB_33DD);
    check_eq("postrst_mem_l1", out1, 32'h11BB_33DD);
    check_eq("postrst_wrcnt", wr1 | wr2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bram_port_responder
`default_nettype wire
